dcpu16_mem: RTL and testbench
=============================

# dcpu16_mem

Dual-port word-addressed memory responder serving the DCPU16 core's two bus initiators: the F bus (instruction fetch and operand save) and the G bus (operand load). Each port runs its own strobe/acknowledge handshake with optional programmable wait states, and both ports share one storage array. The block sits on the far side of the core's bus interface and connects net-for-net to the core's `f_*`/`g_*` ports.

## Interface
- `AW`, default 13: address bits used. Array depth is 2^AW words of 16 bits.
- `WAIT`, default 1: wait states inserted per transfer, range 0..15. Used only when `DCPU16_MEM_WAIT_EN` is defined.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `f_adr` in 16: F-port word address; bits [15:AW] are ignored, so higher addresses alias.
- `f_stb` in 1: F-port request strobe.
- `f_wre` in 1: F-port write enable, 1 = write, 0 = read.
- `f_dto` in 16: F-port write data, driven by the core.
- `f_dti` out 16: F-port read data, returned to the core.
- `f_ack` out 1: F-port acknowledge, a one-cycle pulse.
- `g_adr`, `g_stb`, `g_wre`, `g_dto`, `g_dti`, `g_ack`: G-port equivalents with identical widths and meanings.

## Operation
- Each port has an independent FSM with states IDLE, WAIT and ACK, plus a 4-bit wait counter `cnt`.
- **IDLE:**
  - If `stb`=1 is sampled, latch `adr[AW-1:0]`, `wre` and `dto`, and load `cnt`=WAIT.
  - If WAIT=0, go to ACK; otherwise go to WAIT.
- **WAIT:**
  - Decrement `cnt`.
  - When `cnt` reaches 1, go to ACK.
  - `stb`, `adr` and `dto` are not resampled here; the values latched at accept are used.
- **Entry to ACK:** on the edge that enters ACK, the port performs the transfer:
  - Write: store the latched data at the latched address.
  - Read: load `dti` with the array contents at the latched address.
- **ACK:**
  - `ack`=1 for exactly one cycle.
  - `stb` is ignored during this cycle.
  - Next state is IDLE unconditionally.
- `dti` holds its last read value until the next read completes; writes leave `dti` unchanged.
- A deasserted `stb` during WAIT does not abort the transfer; it still completes and acks.
- **Simultaneous completion on the same edge and the same address:**
  - Both ports write: the G-port data is stored, and the F port still acks.
  - One port reads while the other writes: the read returns the old (pre-write) data.
- **Reset:**
  - Reset values: `f_ack`=0, `g_ack`=0, `f_dti`=0x0000, `g_dti`=0x0000, both FSMs in IDLE, `cnt`=0.
  - Reset asserted mid-transfer discards the pending access; no write occurs and no ack is issued.
  - Array contents are not cleared by reset.

## Timing
- Let `stb` be sampled high at edge k.
- `ack` rises at edge k+WAIT and falls at edge k+WAIT+1.
- `dti` is valid while `ack`=1.
- The earliest next accept is edge k+WAIT+2. Sustained throughput is one transfer per WAIT+2 cycles per port.
- The two ports never stall each other; there is no arbitration.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- `DCPU16_MEM_WAIT_EN` defined: wait counters and the WAIT state are built, and latency follows `WAIT`.
- `DCPU16_MEM_WAIT_EN` undefined:
  - The `WAIT` parameter is ignored and treated as 0, and no counter logic is built.
  - Every transfer acks at edge k: IDLE goes directly to ACK.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, then release. Both `ack` outputs must be 0 and both `dti` outputs 0x0000 during and after reset.
- **F-port write then read, WAIT=1 with macro defined:**
  - Write 0xBEEF to 0x0010; `f_ack` must pulse exactly at edge k+1.
  - Read 0x0010; `f_dti` must be 0xBEEF with `f_ack`.
- **Aliasing, AW=13:** G-port write 0x1234 to 0x2005, then read 0x0005. `g_dti` must be 0x1234.
- **Same-edge same-address conflict, WAIT=0:**
  - F writes 0xAAAA and G writes 0x5555 to 0x0100 on the same edge; both acks must pulse.
  - A subsequent read of 0x0100 must return 0x5555.
- **Read during write:** with 0x0200 holding 0x1111, F reads and G writes 0x2222 on the same edge. `f_dti` must be 0x1111, and a later read must return 0x2222.
- **Reset mid-transfer, WAIT=3:** accept a write of 0xCAFE to 0x0300, then assert `rst` one cycle later.
  - No ack may appear.
  - A read after reset must return the prior contents of 0x0300, not 0xCAFE.

Source files
------------

// File: rtl/dcpu16_mem_if.sv
// Bus bundle between the DCPU16 core and its memory responder.
// Carries the F (fetch/save) and G (load) strobe/acknowledge ports.
interface dcpu16_mem_if;
  logic [15:0] f_adr;
  logic        f_stb;
  logic        f_wre;
  logic [15:0] f_dto;
  logic [15:0] f_dti;
  logic        f_ack;
  logic [15:0] g_adr;
  logic        g_stb;
  logic        g_wre;
  logic [15:0] g_dto;
  logic [15:0] g_dti;
  logic        g_ack;

  modport master (
    output f_adr, f_stb, f_wre, f_dto,
    input  f_dti, f_ack,
    output g_adr, g_stb, g_wre, g_dto,
    input  g_dti, g_ack
  );

  modport slave (
    input  f_adr, f_stb, f_wre, f_dto,
    output f_dti, f_ack,
    input  g_adr, g_stb, g_wre, g_dto,
    output g_dti, g_ack
  );
endinterface

// File: rtl/dcpu16_mem.sv
// Dual-port word memory answering the DCPU16 F and G buses with per-port FSMs.
// Define DCPU16_MEM_WAIT_EN to build the programmable wait-state counters.
module dcpu16_mem #(
  parameter int AW   = 13,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dcpu16_mem_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

`ifdef DCPU16_MEM_WAIT_EN
  localparam logic [3:0] WAIT_C = 4'(WAIT);
  logic [3:0]  cnt_q [2];
`else
  localparam logic [3:0] WAIT_C = 4'd0;
  localparam int unused_wait = WAIT;
`endif

  logic [15:0]   mem_q [0:(1<<AW)-1];

  state_e        state_q [2];
  logic [AW-1:0] adr_q   [2];
  logic          wre_q   [2];
  logic [15:0]   dto_q   [2];
  logic [15:0]   dti_q   [2];
  logic          ack_q   [2];

  // Index 0 is the F port, index 1 the G port; G comes last so it wins write conflicts.
  logic          stb_s  [2];
  logic          wre_s  [2];
  logic [AW-1:0] adr_s  [2];
  logic [15:0]   dto_s  [2];
  logic          xfer_s [2];
  logic          xwre_s [2];
  logic [AW-1:0] xadr_s [2];
  logic [15:0]   xdto_s [2];
  logic          unused_adr_s;

  assign stb_s[0] = bus.f_stb;
  assign stb_s[1] = bus.g_stb;
  assign wre_s[0] = bus.f_wre;
  assign wre_s[1] = bus.g_wre;
  assign adr_s[0] = bus.f_adr[AW-1:0];
  assign adr_s[1] = bus.g_adr[AW-1:0];
  assign dto_s[0] = bus.f_dto;
  assign dto_s[1] = bus.g_dto;
  assign unused_adr_s = ^{bus.f_adr[15:AW], bus.g_adr[15:AW]};

  assign bus.f_dti = dti_q[0];
  assign bus.g_dti = dti_q[1];
  assign bus.f_ack = ack_q[0];
  assign bus.g_ack = ack_q[1];

  // Transfer strobe for the edge entering ACK, with the address/data it uses.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      xfer_s[p] = 1'b0;
      xwre_s[p] = wre_q[p];
      xadr_s[p] = adr_q[p];
      xdto_s[p] = dto_q[p];
      case (state_q[p])
        ST_IDLE: begin
          xwre_s[p] = wre_s[p];
          xadr_s[p] = adr_s[p];
          xdto_s[p] = dto_s[p];
          xfer_s[p] = stb_s[p] && (WAIT_C == 4'd0);
        end
        ST_WAIT: begin
`ifdef DCPU16_MEM_WAIT_EN
          xfer_s[p] = (cnt_q[p] == 4'd1);
`else
          xfer_s[p] = 1'b0;
`endif
        end
        default: begin
          xfer_s[p] = 1'b0;
        end
      endcase
    end
  end

  // Per-port handshake FSMs, request latches and registered read data/ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= ST_IDLE;
        adr_q[p]   <= '0;
        wre_q[p]   <= 1'b0;
        dto_q[p]   <= 16'h0000;
        dti_q[p]   <= 16'h0000;
        ack_q[p]   <= 1'b0;
`ifdef DCPU16_MEM_WAIT_EN
        cnt_q[p]   <= 4'd0;
`endif
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        ack_q[p] <= xfer_s[p];
        if (xfer_s[p] && !xwre_s[p]) begin
          dti_q[p] <= mem_q[xadr_s[p]];
        end
        case (state_q[p])
          ST_IDLE: begin
            if (stb_s[p]) begin
              adr_q[p]   <= adr_s[p];
              wre_q[p]   <= wre_s[p];
              dto_q[p]   <= dto_s[p];
`ifdef DCPU16_MEM_WAIT_EN
              cnt_q[p]   <= WAIT_C;
`endif
              state_q[p] <= (WAIT_C == 4'd0) ? ST_ACK : ST_WAIT;
            end
          end
          ST_WAIT: begin
`ifdef DCPU16_MEM_WAIT_EN
            cnt_q[p] <= cnt_q[p] - 4'd1;
            if (cnt_q[p] == 4'd1) begin
              state_q[p] <= ST_ACK;
            end
`else
            state_q[p] <= ST_IDLE;
`endif
          end
          ST_ACK:  state_q[p] <= ST_IDLE;
          default: state_q[p] <= ST_IDLE;
        endcase
      end
    end
  end

  // Storage array; not reset, and the G port overrides F on a same-address write.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (xfer_s[p] && xwre_s[p]) begin
        mem_q[xadr_s[p]] <= xdto_s[p];
      end
    end
  end

endmodule

// File: tb/tb_dcpu16_mem.sv
// Directed bench for dcpu16_mem: one instance with WAIT=1, one with WAIT=3.
module tb_dcpu16_mem;

`ifdef DCPU16_MEM_WAIT_EN
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`else
  localparam int LAT_A = 0;
  localparam int LAT_B = 0;
`endif

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   chk = 0;
  int   err = 0;
  logic [15:0] f_rd;
  logic [15:0] g_rd;

  always #5 clk = ~clk;

  dcpu16_mem_if bus_a ();
  dcpu16_mem_if bus_b ();

  dcpu16_mem #(.AW(13), .WAIT(1)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
  dcpu16_mem #(.AW(13), .WAIT(3)) u_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request on either or both ports of u_a, check ack timing, capture dti.
  task automatic xfer_a(input string tag,
                        input logic fe, input logic fw, input logic [15:0] fa, input logic [15:0] fd,
                        input logic ge, input logic gw, input logic [15:0] ga, input logic [15:0] gd);
    int n;
    @(negedge clk);
    bus_a.f_stb = fe; bus_a.f_wre = fw; bus_a.f_adr = fa; bus_a.f_dto = fd;
    bus_a.g_stb = ge; bus_a.g_wre = gw; bus_a.g_adr = ga; bus_a.g_dto = gd;
    @(posedge clk);
    #1;
    bus_a.f_stb = 1'b0;
    bus_a.g_stb = 1'b0;
    n = 0;
    while (!(bus_a.f_ack || bus_a.g_ack) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 16'(n), 16'(LAT_A));
    check({tag, " f_ack"}, {15'd0, bus_a.f_ack}, {15'd0, fe});
    check({tag, " g_ack"}, {15'd0, bus_a.g_ack}, {15'd0, ge});
    f_rd = bus_a.f_dti;
    g_rd = bus_a.g_dti;
    @(posedge clk);
    #1;
    check({tag, " ack_fall"}, {14'd0, bus_a.f_ack, bus_a.g_ack}, 16'h0000);
  endtask

  // Single F-port request on u_b.
  task automatic xfer_b(input string tag, input logic fw, input logic [15:0] fa, input logic [15:0] fd);
    int n;
    @(negedge clk);
    bus_b.f_stb = 1'b1; bus_b.f_wre = fw; bus_b.f_adr = fa; bus_b.f_dto = fd;
    @(posedge clk);
    #1;
    bus_b.f_stb = 1'b0;
    n = 0;
    while (!bus_b.f_ack && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 16'(n), 16'(LAT_B));
    f_rd = bus_b.f_dti;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ack_seen;
    bus_a.f_stb = 1'b0; bus_a.f_wre = 1'b0; bus_a.f_adr = 16'h0000; bus_a.f_dto = 16'h0000;
    bus_a.g_stb = 1'b0; bus_a.g_wre = 1'b0; bus_a.g_adr = 16'h0000; bus_a.g_dto = 16'h0000;
    bus_b.f_stb = 1'b0; bus_b.f_wre = 1'b0; bus_b.f_adr = 16'h0000; bus_b.f_dto = 16'h0000;
    bus_b.g_stb = 1'b0; bus_b.g_wre = 1'b0; bus_b.g_adr = 16'h0000; bus_b.g_dto = 16'h0000;
    rst_a = 1'b0;
    rst_b = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst acks", {14'd0, bus_a.f_ack, bus_a.g_ack}, 16'h0000);
    check("rst f_dti", bus_a.f_dti, 16'h0000);
    check("rst g_dti", bus_a.g_dti, 16'h0000);
    check("rst b f_dti", bus_b.f_dti, 16'h0000);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check("post rst acks", {14'd0, bus_a.f_ack, bus_a.g_ack}, 16'h0000);
    check("post rst f_dti", bus_a.f_dti, 16'h0000);
    check("post rst g_dti", bus_a.g_dti, 16'h0000);

    xfer_a("f_wr10", 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    xfer_a("f_rd10", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("f_rd10 data", f_rd, 16'hBEEF);
    xfer_a("f_wr11", 1'b1, 1'b1, 16'h0011, 16'h7777, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("f_dti hold", f_rd, 16'hBEEF);

    xfer_a("g_wr2005", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2005, 16'h1234);
    xfer_a("g_rd0005", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0005, 16'h0000);
    check("alias data", g_rd, 16'h1234);

    xfer_a("dual_wr", 1'b1, 1'b1, 16'h0100, 16'hAAAA, 1'b1, 1'b1, 16'h0100, 16'h5555);
    xfer_a("dual_rd", 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000);
    check("conflict f data", f_rd, 16'h5555);
    check("conflict g data", g_rd, 16'h5555);

    xfer_a("pre200", 1'b1, 1'b1, 16'h0200, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000);
    xfer_a("rdw", 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h2222);
    check("rdw old data", f_rd, 16'h1111);
    xfer_a("rd200", 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("rdw new data", f_rd, 16'h2222);

    xfer_b("b_pre300", 1'b1, 16'h0300, 16'h0BAD);
    @(negedge clk);
    bus_b.f_stb = 1'b1; bus_b.f_wre = 1'b1; bus_b.f_adr = 16'h0300; bus_b.f_dto = 16'hCAFE;
    @(posedge clk);
    #1;
    bus_b.f_stb = 1'b0;
    ack_seen = bus_b.f_ack;
    @(posedge clk);
    #1;
    ack_seen = ack_seen | bus_b.f_ack;
    rst_b = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      ack_seen = ack_seen | bus_b.f_ack;
    end
    check("midrst no ack", {15'd0, ack_seen}, (LAT_B <= 1) ? 16'h0001 : 16'h0000);
    check("midrst dti", bus_b.f_dti, 16'h0000);
    @(negedge clk);
    rst_b = 1'b1;
    xfer_b("b_rd300", 1'b0, 16'h0300, 16'h0000);
    check("midrst data", f_rd, (LAT_B <= 1) ? 16'hCAFE : 16'h0BAD);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
